// File: rtl/image_write.sv
// Pixel stream sink: captures one WIDTH x HEIGHT frame of 8-bit pixels in raster order
// and serves the stored frame through a registered readback port.
module image_write #(
  parameter int unsigned WIDTH  = 768,
  parameter int unsigned HEIGHT = 512,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              VSYNC,
  input  logic              HSYNC,
  input  logic [7:0]        data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              write_done,
  output logic              frame_err,
  output logic [7:0]        frame_cnt,
  output logic [31:0]       pixel_sum
);

  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       acc;
  logic [7:0]        mem [DEPTH];
  logic              wr_en;
  logic              col_last;
  logic              last_pix;

  // VSYNC wins over a coincident HSYNC, so that cycle's pixel is never stored.
  assign wr_en    = (state == RECV) && HSYNC && !VSYNC;
  assign col_last = (col == COL_W'(WIDTH - 1));
  assign last_pix = wr_en && col_last && (row == ROW_W'(HEIGHT - 1));

  always_ff @(posedge HCLK) begin
    if (wr_en) mem[waddr] <= data;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      waddr      <= '0;
      acc        <= '0;
      rd_data    <= '0;
      busy       <= 1'b0;
      write_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
      pixel_sum  <= '0;
    end else begin
      write_done <= 1'b0;
      frame_err  <= 1'b0;
      // Reads see the pre-write contents; out-of-range addresses read as zero.
      rd_data    <= (32'(rd_addr) < DEPTH) ? mem[rd_addr] : 8'd0;
      case (state)
        IDLE, DONE: begin
          if (VSYNC) begin
            state <= RECV;
            busy  <= 1'b1;
            col   <= '0;
            row   <= '0;
            waddr <= '0;
            acc   <= '0;
          end
        end
        RECV: begin
          if (VSYNC) begin
            frame_err <= 1'b1;
            col       <= '0;
            row       <= '0;
            waddr     <= '0;
            acc       <= '0;
          end else if (HSYNC) begin
            acc   <= acc + 32'(data);
            waddr <= waddr + ADDR_W'(1);
            if (col_last) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
            if (last_pix) begin
              write_done <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
              pixel_sum  <= acc + 32'(data);
              state      <= DONE;
              busy       <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
